// File: rtl/slow_data_memory_if.sv
// Line-request bus between the D-cache and the slow data memory, plus the
// word tap that feeds the test monitor and the sticky error flags.
interface slow_data_memory_if #(
  parameter int ADDR_W = 28
);
  logic                mem_read;
  logic                mem_write;
  logic [ADDR_W-1:0]   mem_addr;
  logic [127:0]        mem_wdata;
  logic [127:0]        mem_rdata;
  logic                mem_ready;
  logic [ADDR_W+1:0]   tap_addr;
  logic [31:0]         tap_data;
  logic                tap_wen;
  logic                proto_err;
  logic                oob_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, tap_addr, tap_data, tap_wen, proto_err, oob_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, tap_addr, tap_data, tap_wen, proto_err, oob_err
  );
endinterface

// File: rtl/slow_data_memory.sv
// Fixed-latency 128-bit line memory with a 4-beat word tap for committed writes.
// Define MEM_STAT_EN to add saturating rd_cnt/wr_cnt access counters.
module slow_data_memory #(
  parameter int ADDR_W    = 28,
  parameter int MEM_LINES = 256,
  parameter int LATENCY   = 10
) (
  input  logic clk,
  input  logic rst,
`ifdef MEM_STAT_EN
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
`endif
  slow_data_memory_if.slave bus
);
  localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_reg;
  logic [7:0]          cnt_reg;
  logic                rd_reg;
  logic                wr_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [127:0]        wdata_reg;
  logic                mem_ready_reg;
  logic [127:0]        mem_rdata_reg;
  logic                proto_err_reg;
  logic                oob_err_reg;
  logic                tap_wen_reg;
  logic [ADDR_W+1:0]   tap_addr_reg;
  logic [31:0]         tap_data_reg;
  logic [2:0]          tap_cnt_reg;
  logic [ADDR_W-1:0]   tap_line_reg;
  logic [127:0]        tap_buf_reg;

  logic [127:0]        mem_array [MEM_LINES];

  logic                in_range;
  logic                commit;
  logic                live_mismatch;
  logic [31:0]         tap_words [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tap_words
      assign tap_words[gi] = tap_buf_reg[32*gi +: 32];
    end
  endgenerate

  assign in_range      = ({1'b0, addr_reg} < (ADDR_W+1)'(MEM_LINES));
  assign commit        = (state_reg == RESP) && wr_reg && in_range;
  assign live_mismatch = (bus.mem_read != rd_reg) || (bus.mem_write != wr_reg) ||
                         (bus.mem_addr != addr_reg);

  // The array survives reset; a reset landing on the RESP cycle drops the write.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      mem_array[addr_reg[IDX_W-1:0]] <= wdata_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mem_ready_reg <= 1'b0;
      mem_rdata_reg <= '0;
      proto_err_reg <= 1'b0;
      oob_err_reg   <= 1'b0;
      tap_wen_reg   <= 1'b0;
      tap_addr_reg  <= '0;
      tap_data_reg  <= '0;
      tap_cnt_reg   <= '0;
    end else begin
      mem_ready_reg <= 1'b0;
      mem_rdata_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            rd_reg    <= bus.mem_read;
            wr_reg    <= bus.mem_write;
            addr_reg  <= bus.mem_addr;
            wdata_reg <= bus.mem_wdata;
            cnt_reg   <= 8'(LATENCY - 2);
            state_reg <= WAIT;
            if (bus.mem_read && bus.mem_write) begin
              proto_err_reg <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (live_mismatch) begin
            proto_err_reg <= 1'b1;
          end
          if (cnt_reg == 8'd0) begin
            // Outputs are registered, so ready/rdata are produced on the edge entering RESP.
            state_reg     <= RESP;
            mem_ready_reg <= 1'b1;
            if (!in_range) begin
              oob_err_reg <= 1'b1;
            end
            if (!wr_reg && in_range) begin
              mem_rdata_reg <= mem_array[addr_reg[IDX_W-1:0]];
            end
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      // Own copy of line and data, so a request accepted right after RESP cannot disturb the beats.
      if (commit) begin
        tap_wen_reg  <= 1'b1;
        tap_addr_reg <= {addr_reg, 2'd0};
        tap_data_reg <= wdata_reg[31:0];
        tap_buf_reg  <= wdata_reg;
        tap_line_reg <= addr_reg;
        tap_cnt_reg  <= 3'd1;
      end else if (tap_wen_reg && (tap_cnt_reg != 3'd4)) begin
        tap_addr_reg <= {tap_line_reg, tap_cnt_reg[1:0]};
        tap_data_reg <= tap_words[tap_cnt_reg[1:0]];
        tap_cnt_reg  <= tap_cnt_reg + 3'd1;
      end else begin
        tap_wen_reg <= 1'b0;
      end
    end
  end

`ifdef MEM_STAT_EN
  logic [15:0] rd_cnt_reg;
  logic [15:0] wr_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else if ((state_reg == RESP) && in_range) begin
      if (wr_reg) begin
        if (wr_cnt_reg != 16'hFFFF) wr_cnt_reg <= wr_cnt_reg + 16'd1;
      end else begin
        if (rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_reg;
  assign wr_cnt = wr_cnt_reg;
`endif

  assign bus.mem_ready = mem_ready_reg;
  assign bus.mem_rdata = mem_rdata_reg;
  assign bus.tap_wen   = tap_wen_reg;
  assign bus.tap_addr  = tap_addr_reg;
  assign bus.tap_data  = tap_data_reg;
  assign bus.proto_err = proto_err_reg;
  assign bus.oob_err   = oob_err_reg;
endmodule

// File: tb/tb_slow_data_memory.sv
// Directed plus randomized bench for slow_data_memory against a line-level
// reference model (associative array of lines, queue of expected tap beats).
module tb_slow_data_memory;
  localparam int ADDR_W    = 28;
  localparam int MEM_LINES = 256;
  localparam int LATENCY   = 10;

  typedef struct {
    int                 cyc;
    logic [ADDR_W+1:0]  addr;
    logic [31:0]        data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   exp_proto = 1'b0;
  bit   exp_oob = 1'b0;

  logic [127:0] model [int];
  int           written [$];
  beat_t        tap_q [$];

  slow_data_memory_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef MEM_STAT_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
`endif

  slow_data_memory #(
    .ADDR_W(ADDR_W),
    .MEM_LINES(MEM_LINES),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef MEM_STAT_EN
    .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every tap beat must match the head of the expected-beat queue, including its cycle.
  always @(negedge clk) begin
    beat_t b;
    if (bus.tap_wen !== 1'b0) begin
      if (tap_q.size() == 0) begin
        check("tap_unexpected", {127'b0, bus.tap_wen}, 128'd0);
      end else begin
        b = tap_q.pop_front();
        check("tap_cycle", cyc, b.cyc);
        check("tap_addr", bus.tap_addr, b.addr);
        check("tap_data", bus.tap_data, b.data);
      end
    end
  end

  // Request raised in the current cycle (call just after a rising edge); returns
  // just after the edge following ready, with the request dropped.
  task automatic access(input bit rd, input bit wr, input int a,
                        input logic [127:0] wd, input bit glitch);
    bit           seen;
    bit           is_wr;
    logic [127:0] exp_rd;
    beat_t        b;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = ADDR_W'(a);
    bus.mem_wdata = wd;
    is_wr = wr;
    if ((rd && wr) || glitch) exp_proto = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) check("rdata_idle", bus.mem_rdata, 128'd0);
      if (glitch && k == 3) bus.mem_addr = ADDR_W'(a + 1);
      if (glitch && k == 4) bus.mem_addr = ADDR_W'(a);
      if (bus.mem_ready === 1'b1) begin
        seen = 1'b1;
        check("latency", k, LATENCY);
        if (a >= MEM_LINES) exp_oob = 1'b1;
        if (!is_wr) begin
          exp_rd = (a >= MEM_LINES) ? 128'd0 : model[a];
          check("rdata", bus.mem_rdata, exp_rd);
        end else if (a < MEM_LINES) begin
          if (!model.exists(a)) written.push_back(a);
          model[a] = wd;
          for (int i = 0; i < 4; i++) begin
            b.cyc  = cyc + 1 + i;
            b.addr = (ADDR_W+2)'(a * 4 + i);
            b.data = wd[32*i +: 32];
            tap_q.push_back(b);
          end
        end
        check("proto_err", bus.proto_err, exp_proto);
        check("oob_err", bus.oob_err, exp_oob);
        break;
      end
      if (k == LATENCY - 1) check("rdata_pre", bus.mem_rdata, 128'd0);
    end
    if (!seen) check("ready_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, bus.mem_ready, 128'd0);
    check({tag, "_rdata"}, bus.mem_rdata, 128'd0);
    check({tag, "_tap_wen"}, bus.tap_wen, 128'd0);
    check({tag, "_tap_addr"}, bus.tap_addr, 128'd0);
    check({tag, "_tap_data"}, bus.tap_data, 128'd0);
    check({tag, "_proto"}, bus.proto_err, 128'd0);
    check({tag, "_oob"}, bus.oob_err, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed %0d cycles", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int           ready_hits;
    logic [127:0] line9_old;
    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Line 3 preload, then read it back with exact latency and zero rdata around ready.
    access(1'b0, 1'b1, 3, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    idle(2);
    access(1'b1, 1'b0, 3, '0, 1'b0);
    @(negedge clk);
    check("rdata_after", bus.mem_rdata, 128'd0);
    idle(1);

    // Line 0 with the byte-swapped value 60 in word 0.
    access(1'b0, 1'b1, 0, {32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h3C000000}, 1'b0);
    idle(6);
    access(1'b1, 1'b0, 0, '0, 1'b0);

    // Back-to-back writes: second request raised in the cycle after the first ready.
    access(1'b0, 1'b1, 5, 128'hAAAA0005_BBBB0005_CCCC0005_DDDD0005, 1'b0);
    access(1'b0, 1'b1, 6, 128'hAAAA0006_BBBB0006_CCCC0006_DDDD0006, 1'b0);
    idle(6);

    // Protocol violations: read+write together acts as a write; address glitch during WAIT.
    access(1'b1, 1'b1, 7, 128'h77777777_66666666_55555555_44444444, 1'b0);
    idle(6);
    access(1'b1, 1'b0, 7, '0, 1'b0);
    access(1'b1, 1'b0, 5, '0, 1'b1);
    idle(1);

    // Out-of-range write then read.
    access(1'b0, 1'b1, 300, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, 1'b0);
    idle(6);
    access(1'b1, 1'b0, 300, '0, 1'b0);
    idle(1);

    // Reset in cycle 5 of a write abandons it.
    line9_old = 128'h99990000_99990001_99990002_99990003;
    access(1'b0, 1'b1, 9, line9_old, 1'b0);
    idle(6);
    bus.mem_write = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_addr  = ADDR_W'(9);
    bus.mem_wdata = 128'h12121212_34343434_56565656_78787878;
    idle(5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.mem_write = 1'b0;
    exp_proto     = 1'b0;
    exp_oob       = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_rst");
    ready_hits = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) ready_hits++;
    end
    check("rst_no_ready", ready_hits, 0);
    idle(1);
    access(1'b1, 1'b0, 9, '0, 1'b0);

    // Randomized mix of writes, reads of written lines and out-of-range accesses.
    for (int i = 0; i < 24; i++) begin
      int           a;
      bit           wr;
      logic [127:0] d;
      wr = ($urandom_range(0, 1) == 1) || (written.size() == 0);
      if ($urandom_range(0, 7) == 0) a = 256 + $urandom_range(0, 63);
      else if (wr) a = $urandom_range(0, 15);
      else a = written[$urandom_range(0, written.size() - 1)];
      d = {$urandom, $urandom, $urandom, $urandom};
      access(!wr, wr, a, d, 1'b0);
      idle($urandom_range(0, 2));
    end

    repeat (8) @(negedge clk);
    check("tap_drain", tap_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
